// File: rtl/commit_pkg.sv
// Shared slot type and helpers for the commit reorder buffer.
// Widths here are the configuration the buffer is built for.
package commit_pkg;

  localparam int CP_DW    = 16;
  localparam int CP_RW    = 2 * CP_DW;
  localparam int CP_BLK_W = 8;
  localparam int CP_CH_W  = 4;
  localparam int CP_ID_W  = 9;

  typedef struct packed {
    logic [CP_RW-1:0]    result;
    logic [CP_CH_W-1:0]  dest;
    logic [CP_BLK_W-1:0] block;
    logic                flag;
    logic                is_mac;
  } slot_t;

  function automatic logic [CP_DW-1:0] sat_narrow(
    input logic [CP_RW-1:0] v,
    input logic             sat
  );
    logic [CP_DW-1:0] r;
    r = v[CP_DW-1:0];
    // fits iff every bit above the narrow sign bit matches the wide sign
    if (sat && (v[CP_RW-1:CP_DW-1] != {(CP_DW+1){v[CP_RW-1]}})) begin
      r = v[CP_RW-1] ? {1'b1, {(CP_DW-1){1'b0}}}
                     : {1'b0, {(CP_DW-1){1'b1}}};
    end
    return r;
  endfunction

  function automatic logic [CP_ID_W-1:0] win_offset(
    input logic [CP_ID_W-1:0] id,
    input logic [CP_ID_W-1:0] head
  );
    return id - head;
  endfunction

endpackage

// File: rtl/commit_slot_array.sv
// Reorder window storage: DEPTH slots, one write port per branch,
// one head read port with clear.
module commit_slot_array
  import commit_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int N_BRANCHES = 4,
  parameter int IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [N_BRANCHES-1:0]          wr_en,
  input  logic [N_BRANCHES-1:0][IW-1:0]  wr_idx,
  input  slot_t [N_BRANCHES-1:0]         wr_data,
  input  logic [IW-1:0]                  rd_idx,
  input  logic                           rd_clr,
  output logic [DEPTH-1:0]               valid,
  output slot_t                          rd_data
);

  logic [DEPTH-1:0]  valid_d, valid_q;
  slot_t [DEPTH-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (rd_clr) valid_d[rd_idx] = 1'b0;
    for (int i = 0; i < N_BRANCHES; i++) begin
      if (wr_en[i]) begin
        valid_d[wr_idx[i]] = 1'b1;
        data_d[wr_idx[i]]  = wr_data[i];
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // payload needs no reset: it is only read behind a set valid bit
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid   = valid_q;
  assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/commit_reorder_buffer.sv
// In-order commit stage: parks tagged branch results in a reorder
// window and retires them by ID to the channel file or accumulator.
module commit_reorder_buffer
  import commit_pkg::*;
#(
  parameter int DATA_WIDTH = CP_DW,
  parameter int N_BLOCKS   = 256,
  parameter int N_BRANCHES = 4,
  parameter int MAC_BRANCH = 3,
  parameter int N_CHANNELS = 16,
  parameter int ID_WIDTH   = CP_ID_W,
  parameter int DEPTH      = 8,
  parameter int SATURATE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    sample_tick,
  input  logic [DATA_WIDTH-1:0]   sample_in,
  input  logic [N_BRANCHES-1:0]   in_valid,
  output logic [N_BRANCHES-1:0]   in_ready,
  input  logic [N_BRANCHES-1:0][$clog2(N_BLOCKS)-1:0] block_in,
  input  logic [N_BRANCHES-1:0][2*DATA_WIDTH-1:0]     result,
  input  logic [N_BRANCHES-1:0][$clog2(N_CHANNELS)-1:0] dest,
  input  logic [N_BRANCHES-1:0][ID_WIDTH-1:0]         commit_id,
  input  logic [N_BRANCHES-1:0]   commit_flag,
  output logic [$clog2(N_CHANNELS)-1:0] channel_write_addr,
  output logic [DATA_WIDTH-1:0]   channel_write_val,
  output logic                    channel_write_enable,
  output logic [2*DATA_WIDTH-1:0] accumulator_write_val,
  output logic                    accumulator_write_enable,
  output logic                    accumulator_add_enable,
  output logic [$clog2(N_BLOCKS)-1:0] retire_block,
  output logic [ID_WIDTH-1:0]     next_commit_id,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int CH_W  = $clog2(N_CHANNELS);
  localparam int BLK_W = $clog2(N_BLOCKS);

  logic [N_BRANCHES-1:0]         wr_en;
  logic [N_BRANCHES-1:0][IW-1:0] wr_idx;
  slot_t [N_BRANCHES-1:0]        wr_data;
  logic [N_BRANCHES-1:0]         dup;
  logic [DEPTH-1:0]              slot_valid;
  slot_t                         head_slot;
  logic                          do_tick, do_ret;
  logic [OCC_W-1:0]              n_acc;

  logic [ID_WIDTH-1:0]   head_d, head_q;
  logic [OCC_W-1:0]      occ_d, occ_q;
  logic [CH_W-1:0]       ch_addr_d, ch_addr_q;
  logic [DATA_WIDTH-1:0] ch_val_d, ch_val_q;
  logic                  ch_we_d, ch_we_q;
  logic [2*DATA_WIDTH-1:0] acc_val_d, acc_val_q;
  logic                  acc_we_d, acc_we_q;
  logic                  acc_add_d, acc_add_q;
  logic [BLK_W-1:0]      blk_d, blk_q;

  // a branch yields to any lower-index branch presenting the same ID
  always_comb begin
    dup = '0;
    for (int i = 0; i < N_BRANCHES; i++) begin
      for (int j = 0; j < i; j++) begin
        if (in_valid[j] && (commit_id[j] == commit_id[i])) dup[i] = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    wr_en    = '0;
    wr_idx   = '0;
    wr_data  = '0;
    n_acc    = '0;
    for (int i = 0; i < N_BRANCHES; i++) begin
      wr_idx[i] = commit_id[i][IW-1:0];
      in_ready[i] = enable && !flush && !dup[i]
                 && (int'(win_offset(commit_id[i], head_q)) < DEPTH)
                 && !slot_valid[commit_id[i][IW-1:0]];
      wr_en[i] = in_valid[i] && in_ready[i];
      wr_data[i].result = result[i];
      wr_data[i].dest   = dest[i];
      wr_data[i].block  = block_in[i];
      wr_data[i].flag   = commit_flag[i];
      wr_data[i].is_mac = (i == MAC_BRANCH);
      n_acc = n_acc + OCC_W'(wr_en[i]);
    end
  end

  commit_slot_array #(
    .DEPTH      (DEPTH),
    .N_BRANCHES (N_BRANCHES),
    .IW         (IW)
  ) u_slots (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (head_q[IW-1:0]),
    .rd_clr  (do_ret),
    .valid   (slot_valid),
    .rd_data (head_slot)
  );

  always_comb begin
    do_tick   = enable && !flush && sample_tick;
    do_ret    = enable && !flush && !sample_tick
             && slot_valid[head_q[IW-1:0]];
    head_d    = head_q + ID_WIDTH'(do_ret);
    occ_d     = occ_q + n_acc - OCC_W'(do_ret);
    ch_addr_d = ch_addr_q;
    ch_val_d  = ch_val_q;
    ch_we_d   = 1'b0;
    acc_val_d = acc_val_q;
    acc_we_d  = 1'b0;
    acc_add_d = 1'b0;
    blk_d     = blk_q;
    if (flush) begin
      head_d = '0;
      occ_d  = '0;
    end
    if (do_tick) begin
      ch_addr_d = '0;
      ch_val_d  = sample_in;
      ch_we_d   = 1'b1;
    end else if (do_ret) begin
      blk_d = head_slot.block;
      if (head_slot.is_mac) begin
        acc_val_d = head_slot.result;
        acc_we_d  = 1'b1;
        acc_add_d = !head_slot.flag;
      end else begin
        ch_addr_d = head_slot.dest;
        ch_val_d  = sat_narrow(head_slot.result, SATURATE != 0);
        ch_we_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      occ_q     <= '0;
      ch_addr_q <= '0;
      ch_val_q  <= '0;
      ch_we_q   <= 1'b0;
      acc_val_q <= '0;
      acc_we_q  <= 1'b0;
      acc_add_q <= 1'b0;
      blk_q     <= '0;
    end else begin
      head_q    <= head_d;
      occ_q     <= occ_d;
      ch_addr_q <= ch_addr_d;
      ch_val_q  <= ch_val_d;
      ch_we_q   <= ch_we_d;
      acc_val_q <= acc_val_d;
      acc_we_q  <= acc_we_d;
      acc_add_q <= acc_add_d;
      blk_q     <= blk_d;
    end
  end

  assign channel_write_addr       = ch_addr_q;
  assign channel_write_val        = ch_val_q;
  assign channel_write_enable     = ch_we_q;
  assign accumulator_write_val    = acc_val_q;
  assign accumulator_write_enable = acc_we_q;
  assign accumulator_add_enable   = acc_add_q;
  assign retire_block             = blk_q;
  assign next_commit_id           = head_q;
  assign occupancy                = occ_q;

endmodule

// File: tb/tb_commit_reorder_buffer.sv
// Directed bench for commit_reorder_buffer: a truncating and a
// saturating instance share one stimulus stream.
module tb_commit_reorder_buffer;

  logic clk = 1'b0;
  logic reset, enable, flush, sample_tick;
  logic [15:0] sample_in;
  logic [3:0] in_valid;
  logic [3:0] in_ready, s_in_ready;
  logic [3:0][7:0]  block_in;
  logic [3:0][31:0] result;
  logic [3:0][3:0]  dest;
  logic [3:0][8:0]  commit_id;
  logic [3:0]       commit_flag;

  logic [3:0]  ch_addr, s_ch_addr;
  logic [15:0] ch_val, s_ch_val;
  logic        ch_we, s_ch_we;
  logic [31:0] acc_val, s_acc_val;
  logic        acc_we, s_acc_we, acc_add, s_acc_add;
  logic [7:0]  blk, s_blk;
  logic [8:0]  next_id, s_next_id;
  logic [3:0]  occ, s_occ;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  commit_reorder_buffer #(.SATURATE(0)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .sample_tick(sample_tick), .sample_in(sample_in),
    .in_valid(in_valid), .in_ready(in_ready), .block_in(block_in),
    .result(result), .dest(dest), .commit_id(commit_id),
    .commit_flag(commit_flag),
    .channel_write_addr(ch_addr), .channel_write_val(ch_val),
    .channel_write_enable(ch_we), .accumulator_write_val(acc_val),
    .accumulator_write_enable(acc_we),
    .accumulator_add_enable(acc_add), .retire_block(blk),
    .next_commit_id(next_id), .occupancy(occ)
  );

  commit_reorder_buffer #(.SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .sample_tick(sample_tick), .sample_in(sample_in),
    .in_valid(in_valid), .in_ready(s_in_ready), .block_in(block_in),
    .result(result), .dest(dest), .commit_id(commit_id),
    .commit_flag(commit_flag),
    .channel_write_addr(s_ch_addr), .channel_write_val(s_ch_val),
    .channel_write_enable(s_ch_we), .accumulator_write_val(s_acc_val),
    .accumulator_write_enable(s_acc_we),
    .accumulator_add_enable(s_acc_add), .retire_block(s_blk),
    .next_commit_id(s_next_id), .occupancy(s_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_valid = 4'b0;
  endtask

  task automatic set_br(input int b, input logic [8:0] id,
                        input logic [3:0] d, input logic [31:0] r,
                        input logic f, input logic [7:0] bk);
    in_valid[b]    = 1'b1;
    commit_id[b]   = id;
    dest[b]        = d;
    result[b]      = r;
    commit_flag[b] = f;
    block_in[b]    = bk;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; flush = 1'b0; sample_tick = 1'b0;
    sample_in = 16'h0; in_valid = 4'b0; block_in = '0; result = '0;
    dest = '0; commit_id = '0; commit_flag = 4'b0;
    #12;
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_next", 32'(next_id), 32'd0);
    chk("rst_ch_we", 32'(ch_we), 32'd0);
    chk("rst_acc_we", 32'(acc_we), 32'd0);
    chk("rst_ch_val", 32'(ch_val), 32'd0);
    chk("rst_acc_val", acc_val, 32'd0);
    reset = 1'b0; enable = 1'b1;

    // out-of-order fill
    set_br(0, 9'd2, 4'd5, 32'h3, 1'b0, 8'hA2);
    set_br(1, 9'd1, 4'd4, 32'h2, 1'b0, 8'hA1);
    #1 chk("ooo_rdy", 32'(in_ready[1:0]), 32'h3);
    tick();
    chk("ooo_occ2", 32'(occ), 32'd2);
    chk("ooo_nowr", 32'(ch_we), 32'd0);
    clr(); set_br(2, 9'd0, 4'd3, 32'h1, 1'b0, 8'hA0);
    tick();
    chk("ooo_occ3", 32'(occ), 32'd3);
    chk("ooo_nowr2", 32'(ch_we), 32'd0);
    clr(); tick();
    chk("ooo_we0", 32'(ch_we), 32'd1);
    chk("ooo_wr0", {ch_addr, ch_val}, {4'd3, 16'h1});
    chk("ooo_blk0", 32'(blk), 32'hA0);
    chk("ooo_occ_a", 32'(occ), 32'd2);
    tick();
    chk("ooo_wr1", {ch_we, ch_addr, ch_val}, {1'b1, 4'd4, 16'h2});
    tick();
    chk("ooo_wr2", {ch_we, ch_addr, ch_val}, {1'b1, 4'd5, 16'h3});
    chk("ooo_next", 32'(next_id), 32'd3);
    chk("ooo_occ0", 32'(occ), 32'd0);

    // MAC path
    set_br(3, 9'd3, 4'd0, 32'h00012345, 1'b0, 8'hB3);
    tick();
    chk("mac_occ", 32'(occ), 32'd1);
    clr(); tick();
    chk("mac_we0", {acc_we, acc_add}, 32'h3);
    chk("mac_val0", acc_val, 32'h00012345);
    chk("mac_noch0", 32'(ch_we), 32'd0);
    chk("mac_blk", 32'(blk), 32'hB3);
    set_br(3, 9'd4, 4'd0, 32'h55, 1'b1, 8'hB4);
    tick();
    chk("mac_pulse", 32'(acc_we), 32'd0);
    clr(); tick();
    chk("mac_we1", {acc_we, acc_add}, 32'h2);
    chk("mac_val1", acc_val, 32'h55);
    chk("mac_noch1", 32'(ch_we), 32'd0);
    chk("mac_next", 32'(next_id), 32'd5);

    // narrowing
    set_br(0, 9'd5, 4'd7, 32'h00012345, 1'b0, 8'h0);
    set_br(1, 9'd6, 4'd7, 32'hFFFE0000, 1'b0, 8'h0);
    set_br(2, 9'd7, 4'd7, 32'hFFFFFFF0, 1'b0, 8'h0);
    tick(); clr(); tick();
    chk("tr_pos", 32'(ch_val), 32'h2345);
    chk("sat_pos", 32'(s_ch_val), 32'h7FFF);
    tick();
    chk("tr_neg", 32'(ch_val), 32'h0000);
    chk("sat_neg", 32'(s_ch_val), 32'h8000);
    tick();
    chk("tr_small", 32'(ch_val), 32'hFFF0);
    chk("sat_small", 32'(s_ch_val), 32'hFFF0);
    chk("sat_next", 32'(next_id), 32'd8);

    // sample tick collides with a valid head
    set_br(0, 9'd8, 4'd2, 32'h77, 1'b0, 8'h0);
    tick(); clr();
    sample_tick = 1'b1; sample_in = 16'h1234;
    set_br(1, 9'd9, 4'd6, 32'h99, 1'b0, 8'h0);
    #1 chk("tick_rdy", 32'(in_ready[1]), 32'd1);
    tick();
    chk("tick_wr", {ch_we, ch_addr, ch_val}, {1'b1, 4'd0, 16'h1234});
    chk("tick_hold", 32'(next_id), 32'd8);
    chk("tick_occ", 32'(occ), 32'd2);
    sample_tick = 1'b0; clr(); tick();
    chk("tick_ret", {ch_we, ch_addr, ch_val}, {1'b1, 4'd2, 16'h77});
    tick();
    chk("tick_ret2", {ch_we, ch_addr, ch_val}, {1'b1, 4'd6, 16'h99});
    chk("tick_occ0", 32'(occ), 32'd0);

    // stream up to the wrap point
    for (int k = 10; k < 510; k++) begin
      clr(); set_br(0, 9'(k), 4'd1, 32'(k), 1'b0, 8'h0);
      tick();
    end
    clr(); tick();
    chk("strm_next", 32'(next_id), 32'd510);
    chk("strm_val", 32'(ch_val), 32'h01FD);
    chk("strm_occ", 32'(occ), 32'd0);

    set_br(0, 9'd3, 4'd1, 32'h303, 1'b0, 8'h0);
    set_br(1, 9'd6, 4'd1, 32'h606, 1'b0, 8'h0);
    #1 chk("win_in", 32'(in_ready[1:0]), 32'h1);
    tick();
    in_valid[0] = 1'b0;
    set_br(2, 9'd510, 4'd1, 32'h5FE, 1'b0, 8'h0);
    #1 chk("win_stall", 32'(in_ready[1]), 32'd0);
    tick();
    set_br(2, 9'd511, 4'd1, 32'h5FF, 1'b0, 8'h0);
    tick();
    chk("wrap_510", {ch_we, ch_val}, {1'b1, 16'h05FE});
    chk("wrap_n511", 32'(next_id), 32'd511);
    chk("win_open", 32'(in_ready[1]), 32'd1);
    set_br(2, 9'd0, 4'd1, 32'h600, 1'b0, 8'h0);
    tick();
    chk("wrap_511", {ch_we, ch_val}, {1'b1, 16'h05FF});
    chk("wrap_n0", 32'(next_id), 32'd0);
    clr(); tick();
    chk("wrap_0", {ch_we, ch_val}, {1'b1, 16'h0600});
    chk("wrap_n1", 32'(next_id), 32'd1);
    chk("wrap_occ", 32'(occ), 32'd2);

    // flush with five slots held
    set_br(0, 9'd1, 4'd1, 32'h1, 1'b0, 8'h0);
    set_br(1, 9'd2, 4'd1, 32'h2, 1'b0, 8'h0);
    set_br(2, 9'd4, 4'd1, 32'h4, 1'b0, 8'h0);
    tick();
    chk("fl_occ5", 32'(occ), 32'd5);
    clr(); flush = 1'b1; sample_tick = 1'b1;
    set_br(0, 9'd5, 4'd1, 32'h5, 1'b0, 8'h0);
    #1 chk("fl_rdy", 32'(in_ready), 32'h0);
    tick();
    chk("fl_occ", 32'(occ), 32'd0);
    chk("fl_next", 32'(next_id), 32'd0);
    chk("fl_we", {ch_we, acc_we}, 32'h0);
    flush = 1'b0; sample_tick = 1'b0; clr();

    // duplicate ID, then async reset mid-retire
    set_br(0, 9'd0, 4'd9, 32'h42, 1'b0, 8'hC0);
    set_br(1, 9'd0, 4'd8, 32'h43, 1'b0, 8'hC1);
    #1 chk("dup_rdy", 32'(in_ready[1:0]), 32'h1);
    tick();
    chk("dup_occ", 32'(occ), 32'd1);
    in_valid[0] = 1'b0;
    set_br(1, 9'd1, 4'd8, 32'h43, 1'b0, 8'hC1);
    tick();
    chk("pre_rst", {ch_we, ch_addr, ch_val}, {1'b1, 4'd9, 16'h42});
    #2 reset = 1'b1;
    #1;
    chk("ar_we", {ch_we, acc_we, acc_add}, 32'h0);
    chk("ar_data", {ch_addr, ch_val, blk}, 32'h0);
    chk("ar_next", 32'(next_id), 32'd0);
    chk("ar_occ", 32'(occ), 32'd0);
    reset = 1'b0; clr(); tick();
    chk("ar_clear", {ch_we, occ}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/commit_reorder_buffer.md
Name: commit_reorder_buffer

Overview:
- In-order commit stage with a reorder window, fed by all instruction branches.
- Accepts out-of-order branch results tagged with commit IDs and parks them in a DEPTH-slot window.
- Retires them strictly in ID order to the channel register file or the MAC accumulator.
- Parametrised successor of the single-match commit stage: adds buffering, a configurable branch count, an optional saturating narrowing mode, a flush, and an occupancy count.

Parameters:
- DATA_WIDTH, 16, channel sample width; results are 2*DATA_WIDTH.
- N_BLOCKS, 256, block count; block tag width is clog2(N_BLOCKS).
- N_BRANCHES, 4, number of result-producing branches.
- MAC_BRANCH, 3, index of the branch whose results target the accumulator.
- N_CHANNELS, 16, channel register count; address width CH_W = clog2(N_CHANNELS).
- ID_WIDTH, 9, commit ID width; IDs wrap modulo 2^ID_WIDTH.
- DEPTH, 8, window slots; power of two, at most 2^ID_WIDTH.
- SATURATE, 0, 1 = saturate 2W->W on channel writes; 0 = truncate to low W bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  global run enable
- flush  in  1  synchronous clear of window and ID counter
- sample_tick  in  1  new input sample strobe
- sample_in  in  DATA_WIDTH  signed sample, written to channel 0
- in_valid  in  N_BRANCHES  per-branch result valid
- in_ready  out  N_BRANCHES  per-branch accept (combinational)
- block_in  in  N_BRANCHES x clog2(N_BLOCKS)  block tag, stored and forwarded
- result  in  N_BRANCHES x 2*DATA_WIDTH  result value
- dest  in  N_BRANCHES x CH_W  destination channel
- commit_id  in  N_BRANCHES x ID_WIDTH  commit tag
- commit_flag  in  N_BRANCHES  MAC: 1 = overwrite, 0 = add
- channel_write_addr  out  CH_W  registered
- channel_write_val  out  DATA_WIDTH  registered
- channel_write_enable  out  1  one-cycle pulse
- accumulator_write_val  out  2*DATA_WIDTH  registered
- accumulator_write_enable  out  1  one-cycle pulse
- accumulator_add_enable  out  1  one-cycle pulse, qualified by write_enable
- retire_block  out  clog2(N_BLOCKS)  block tag of last retire
- next_commit_id  out  ID_WIDTH  head ID of the window
- occupancy  out  clog2(DEPTH)+1  number of occupied slots

Behaviour:
- Reset (async): all slot valid bits 0, next_commit_id 0, occupancy 0, every enable 0, all data outputs 0.
- Window membership: offset = (commit_id[i] - next_commit_id) mod 2^ID_WIDTH. In window iff offset < DEPTH. Slot = commit_id[i] mod DEPTH.
- in_ready[i] = enable & !flush & in-window & target slot empty & no lower-index branch valid with the same ID this cycle.
- Out-of-window or duplicate IDs stall; they are never dropped.
- Multiple branches may be accepted in one cycle (distinct IDs map to distinct slots).
- Accept on valid & ready at the clock edge: slot stores result, dest, block, flag, and is_mac (i == MAC_BRANCH).
- Retire, per cycle with enable & !sample_tick & !flush, if head slot valid:
  - Clear the slot and increment next_commit_id with wrap.
  - If is_mac: drive accumulator_write_val = result, write_enable = 1, add_enable = ~flag.
  - Else: drive channel_write_addr = dest, channel_write_val = narrow(result), write_enable = 1.
  - retire_block is updated on every retire.
- At most one retire per cycle.
- Narrowing:
  - SATURATE = 0: low DATA_WIDTH bits.
  - SATURATE = 1: clamp the signed 2W value to [-2^(W-1), 2^(W-1)-1].
- Latency: a result accepted at edge N retires at edge N+1 at earliest if it is the head. Outputs are visible in the following cycle.
- sample_tick (with enable) has priority over retire: writes channel 0 = sample_in, suppresses retire that cycle. Acceptance is unaffected.
- The same slot may not be freed and refilled in the same edge: in_ready uses pre-edge slot state.
- occupancy = accepts - retires, updated every edge. Never exceeds DEPTH.
- flush: clears all slot valid bits, next_commit_id <= 0, occupancy <= 0, no writes that cycle, in_ready = 0. flush has priority over sample_tick.
- enable = 0: no accept, no retire, no writes. State is held.
- Write enables are pulses: default 0 every cycle. Data outputs hold their last value.

Decomposition:
- Package commit_pkg holds:
  - the slot struct {result, dest, block, flag, is_mac};
  - saturate function sat_narrow;
  - the window-offset function.
- One natural sub-module: commit_slot_array, DEPTH slots with N_BRANCHES write ports and one head read port.

Test Plan:
- Out-of-order fill: with next_id=0, branch0 id=2 dest=5 res=0x0003, branch1 id=1 dest=4 res=0x0002, then branch2 id=0 dest=3 res=0x0001 -> channel writes (3,1),(4,2),(5,3) on consecutive cycles; next_commit_id=3; occupancy peaks at 3.
- MAC path: MAC_BRANCH delivers id=0 res=0x00012345 flag=0, then id=1 flag=1 -> accumulator pulses with add_enable 1 then 0; no channel write occurs.
- Window and ID wrap:
  - next_id=510, DEPTH=8: id=3 is accepted (offset 5).
  - id=6 stalls (offset 8) until next_id advances to 511.
  - IDs 510, 511, 0 retire in that order.
- Saturation, SATURATE=1, W=16:
  - res=0x00012345 -> 0x7FFF.
  - res=0xFFFE0000 -> 0x8000.
  - res=0xFFFFFFF0 -> 0xFFF0.
  - SATURATE=0: res=0x00012345 -> 0x2345.
- Tick collision: head valid while sample_tick=1, sample_in=0x1234 -> write (0,0x1234) that cycle; the head retires the next cycle; a same-cycle accept still occurs.
- Flush and async reset:
  - flush with 5 slots full -> occupancy 0, next_id 0, no write pulses.
  - Reset asserted mid-retire between edges -> all enables 0 immediately, state cleared.
